// File: rtl/dcache_wb_buffer_pkg.sv
// Shared widths, AXI constants and drain FSM state type for the data-cache
// write-back buffer.
package dcache_wb_buffer_pkg;

    localparam int LINE_W     = 512;
    localparam int STRB_W     = 64;
    localparam int TAG_W      = 26;
    localparam int LINE_BEATS = 16;
    localparam int BEAT_W     = 4;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [7:0] AXI_LEN_LINE   = 8'd15;

    typedef enum logic [1:0] {
        WBUF_IDLE = 2'd0,
        WBUF_AW   = 2'd1,
        WBUF_W    = 2'd2,
        WBUF_B    = 2'd3
    } wbuf_state_e;

endpackage

// File: rtl/dcache_wbuf_fifo.sv
// Line storage queue for the write-back buffer: pointers, occupancy and a
// parallel tag compare against every valid entry (including the one draining).
module dcache_wbuf_fifo
    import dcache_wb_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [LINE_W-1:0]      push_data_i,
    input  logic [STRB_W-1:0]      push_strb_i,
    input  logic [TAG_W-1:0]       push_tag_i,
    input  logic [TAG_W-1:0]       query_tag_i,
    output logic [LINE_W-1:0]      head_data_o,
    output logic [STRB_W-1:0]      head_strb_o,
    output logic [TAG_W-1:0]       head_tag_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   query_hit_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [LINE_W-1:0] data_q [DEPTH];
    logic [STRB_W-1:0] strb_q [DEPTH];
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok_s, pop_ok_s;

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == {CNT_W{1'b0}});
    assign count_o     = count_q;
    assign push_ok_s   = push_i && !full_o;
    assign pop_ok_s    = pop_i && !empty_o;
    assign head_data_o = data_q[rd_ptr_q];
    assign head_strb_o = strb_q[rd_ptr_q];
    assign head_tag_o  = tag_q[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue state; push and pop never target the same slot in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            valid_q  <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= {LINE_W{1'b0}};
                strb_q[i] <= {STRB_W{1'b0}};
                tag_q[i]  <= {TAG_W{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok_s) begin
                data_q[wr_ptr_q]  <= push_data_i;
                strb_q[wr_ptr_q]  <= push_strb_i;
                tag_q[wr_ptr_q]   <= push_tag_i;
                valid_q[wr_ptr_q] <= 1'b1;
            end
            if (pop_ok_s) begin
                valid_q[rd_ptr_q] <= 1'b0;
            end
        end
    end

    // Line-address match against all occupied slots.
    always_comb begin
        query_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == query_tag_i)) begin
                query_hit_o = 1'b1;
            end else begin
                query_hit_o = query_hit_o;
            end
        end
    end

endmodule

// File: rtl/dcache_wb_buffer.sv
// Data-cache write-back buffer: queues dirty lines and drains each as a
// 16-beat AXI4 INCR write burst, stalling the pipeline when the queue is full.
module dcache_wb_buffer
    import dcache_wb_buffer_pkg::*;
#(
    parameter int         DEPTH  = 2,
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINE_W-1:0] wb_data_cache_write,
    input  logic [STRB_W-1:0] wb_data_strb_cache,
    input  logic [31:0]       wb_addr_cache,
    output logic              stallreq,
    input  logic [31:0]       query_addr,
    output logic              query_hit,
    output logic              buf_empty,
    output logic              wb_err,
    output logic [3:0]        awid,
    output logic [31:0]       awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [3:0]        bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wbuf_state_e       state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              wb_err_q, wb_err_d;
    logic              push_req_s, pop_s, fifo_full_s, fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [LINE_W-1:0] head_data_s;
    logic [STRB_W-1:0] head_strb_s;
    logic [TAG_W-1:0]  head_tag_s;
    logic              unused_s;

    assign push_req_s = |wb_data_strb_cache;
    assign stallreq   = push_req_s && fifo_full_s;
    assign buf_empty  = fifo_empty_s && (state_q == WBUF_IDLE);
    assign wb_err     = wb_err_q;
    assign awid       = AXI_ID;
    assign unused_s   = ^{bid, wb_addr_cache[5:0], query_addr[5:0]};

    dcache_wbuf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_req_s),
        .pop_i       (pop_s),
        .push_data_i (wb_data_cache_write),
        .push_strb_i (wb_data_strb_cache),
        .push_tag_i  (wb_addr_cache[31:6]),
        .query_tag_i (query_addr[31:6]),
        .head_data_o (head_data_s),
        .head_strb_o (head_strb_s),
        .head_tag_o  (head_tag_s),
        .count_o     (fifo_count_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .query_hit_o (query_hit)
    );

    // Drain FSM next-state, beat counter and head pop.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        pop_s    = 1'b0;
        wb_err_d = 1'b0;
        case (state_q)
            WBUF_IDLE: begin
                if (!fifo_empty_s) state_d = WBUF_AW;
                else               state_d = WBUF_IDLE;
            end
            WBUF_AW: begin
                if (awready) state_d = WBUF_W;
                else         state_d = WBUF_AW;
            end
            WBUF_W: begin
                if (wready && (beat_q == 4'd15)) begin
                    state_d = WBUF_B;
                    beat_d  = 4'd0;
                end else if (wready) begin
                    beat_d = beat_q + 4'd1;
                end else begin
                    beat_d = beat_q;
                end
            end
            WBUF_B: begin
                if (bvalid) begin
                    pop_s    = 1'b1;
                    wb_err_d = (bresp != 2'b00);
                    // Count still includes the line being retired.
                    if (fifo_count_s > CNT_W'(1)) state_d = WBUF_AW;
                    else                          state_d = WBUF_IDLE;
                end else begin
                    state_d = WBUF_B;
                end
            end
            default: state_d = WBUF_IDLE;
        endcase
    end

    // FSM, beat and error-pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= WBUF_IDLE;
            beat_q   <= 4'd0;
            wb_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            wb_err_q <= wb_err_d;
        end
    end

    // AXI channel outputs; payloads read zero outside their phase.
    always_comb begin
        awvalid = 1'b0;
        awaddr  = 32'h0;
        awlen   = 8'h0;
        awsize  = 3'h0;
        awburst = 2'h0;
        wvalid  = 1'b0;
        wdata   = 32'h0;
        wstrb   = 4'h0;
        wlast   = 1'b0;
        bready  = 1'b0;
        case (state_q)
            WBUF_AW: begin
                awvalid = 1'b1;
                awaddr  = {head_tag_s, 6'b000000};
                awlen   = AXI_LEN_LINE;
                awsize  = AXI_SIZE_4B;
                awburst = AXI_BURST_INCR;
            end
            WBUF_W: begin
                wvalid = 1'b1;
                wdata  = head_data_s[{beat_q, 5'b00000} +: 32];
                wstrb  = head_strb_s[{beat_q, 2'b00} +: 4];
                wlast  = (beat_q == 4'd15);
            end
            WBUF_B:  bready = 1'b1;
            default: bready = 1'b0;
        endcase
    end

endmodule
